// File: rtl/fft_mag_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_mag_stream
// Purpose  : Aligns a frame strobe with the FFT latency, captures bins
//            0..SIZE/2-1 and streams one saturated power word per bin.
// Revision : 1.0  initial release
// ============================================================================
module fft_mag_stream #(
   parameter int SIZE  = 64,
   parameter int RN    = 16,
   parameter int OUTN  = 16,
   parameter int SHIFT = 16,
   localparam int IW   = (SIZE > 2) ? $clog2(SIZE) - 1 : 1
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 start,
   input  logic signed [RN-1:0] fft [SIZE][2],
   output logic [OUTN-1:0]      out_data,
   output logic [IW-1:0]        out_idx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy,
   output logic                 overrun
);

   localparam int LAT = $clog2(SIZE) + 1;
   localparam int CW  = $clog2(SIZE);
   localparam int HN  = 2 ** IW;
   localparam logic [CW-1:0] LAST_BIN = CW'(SIZE / 2 - 1);
   localparam logic [CW-1:0] NBINS    = CW'(SIZE / 2);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t               state;
   logic [LAT-1:0]       dly;
   logic [CW-1:0]        idx;
   logic signed [RN-1:0] hold [HN][2];

   logic                   cap;
   logic                   hs_last;
   logic                   take;
   logic                   load;
   logic signed [RN-1:0]   sel_re;
   logic signed [RN-1:0]   sel_im;
   logic signed [2*RN-1:0] re_x;
   logic signed [2*RN-1:0] im_x;
   logic signed [2*RN-1:0] re_sq;
   logic signed [2*RN-1:0] im_sq;
   logic [2*RN-1:0]        pwr;
   logic [2*RN-1:0]        q;
   logic [OUTN-1:0]        sat_data;
   logic                   unused_upper;

   assign cap     = dly[LAT-1];
   assign hs_last = out_valid && out_ready && out_last;
   // A new frame is accepted when idle or exactly as the last word retires.
   assign take    = cap && ((state == IDLE) || ((state == STREAM) && hs_last));
   assign load    = (state == STREAM) && (idx < NBINS) && (!out_valid || out_ready);

   assign sel_re = hold[idx[IW-1:0]][0];
   assign sel_im = hold[idx[IW-1:0]][1];
   assign re_x   = {{RN{sel_re[RN-1]}}, sel_re};
   assign im_x   = {{RN{sel_im[RN-1]}}, sel_im};
   assign re_sq  = re_x * re_x;
   assign im_sq  = im_x * im_x;
   assign pwr    = $unsigned(re_sq) + $unsigned(im_sq);
   assign q      = pwr >> SHIFT;

   generate
      if (OUTN < 2 * RN) begin : g_sat
         assign sat_data = (|q[2*RN-1:OUTN]) ? {OUTN{1'b1}} : q[OUTN-1:0];
      end else begin : g_nosat
         assign sat_data = OUTN'(q);
      end
   endgenerate

   // Upper FFT bins are redundant for a real input signal.
   always_comb begin
      unused_upper = 1'b0;
      for (int k = HN; k < SIZE; k++) begin
         unused_upper = unused_upper ^ (^fft[k][0]) ^ (^fft[k][1]);
      end
   end

   always_ff @(posedge clk) begin
      if (take) begin
         for (int k = 0; k < HN; k++) begin
            hold[k][0] <= fft[k][0];
            hold[k][1] <= fft[k][1];
         end
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state     <= IDLE;
         dly       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         dly     <= {dly[LAT-2:0], start};
         overrun <= 1'b0;

         if (load) begin
            out_data  <= sat_data;
            out_idx   <= idx[IW-1:0];
            out_last  <= (idx == LAST_BIN);
            out_valid <= 1'b1;
            idx       <= idx + CW'(1);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (take) begin
                  state <= STREAM;
                  busy  <= 1'b1;
                  idx   <= '0;
               end
            end
            STREAM: begin
               if (take) begin
                  idx <= '0;
               end else if (hs_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cap) begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_mag_stream.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for fft_mag_stream: two instances (SHIFT=16 and SHIFT=14) share all
// stimulus; words are collected at the falling edge and compared to a model.
module tb_fft_mag_stream;

   localparam int SIZE = 8;
   localparam int RN   = 16;
   localparam int OUTN = 16;
   localparam int LAT  = $clog2(SIZE) + 1;
   localparam int HALF = SIZE / 2;
   localparam int IW   = $clog2(SIZE) - 1;

   logic                 clk = 1'b0;
   logic                 n_reset;
   logic                 start;
   logic                 out_ready;
   logic signed [RN-1:0] fft [SIZE][2];

   logic [OUTN-1:0] d16, d14;
   logic [IW-1:0]   i16, i14;
   logic            v16, v14, l16, l14, b16, b14, o16, o14;

   always #5 clk = ~clk;

   fft_mag_stream #(.SIZE(SIZE), .RN(RN), .OUTN(OUTN), .SHIFT(16)) u16 (
      .clk(clk), .n_reset(n_reset), .start(start), .fft(fft),
      .out_data(d16), .out_idx(i16), .out_valid(v16), .out_ready(out_ready),
      .out_last(l16), .busy(b16), .overrun(o16));

   fft_mag_stream #(.SIZE(SIZE), .RN(RN), .OUTN(OUTN), .SHIFT(14)) u14 (
      .clk(clk), .n_reset(n_reset), .start(start), .fft(fft),
      .out_data(d14), .out_idx(i14), .out_valid(v14), .out_ready(out_ready),
      .out_last(l14), .busy(b14), .overrun(o14));

   typedef struct {
      logic [HALF-1:0][RN-1:0]   re;
      logic [HALF-1:0][RN-1:0]   im;
      logic [HALF-1:0][OUTN-1:0] e16;
      logic [HALF-1:0][OUTN-1:0] e14;
   } vec_t;

   typedef struct {
      logic [OUTN-1:0] data;
      logic [IW-1:0]   idx;
      logic            last;
      int              cyc;
   } word_t;

   vec_t  tab[$];
   word_t q16[$];
   word_t q14[$];

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int ov16_n = 0, ov16_cyc = -1, ov14_n = 0, vcnt = 0;

   bit              hold_p = 1'b0;
   logic [OUTN-1:0] hd;
   logic [IW-1:0]   hi;
   logic            hl;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference power: exact integer arithmetic, then shift and clamp.
   function automatic logic [OUTN-1:0] pw(input logic [RN-1:0] re, input logic [RN-1:0] im, input int sh);
      longint r, i, p, qq;
      r  = longint'($signed(re));
      i  = longint'($signed(im));
      p  = r * r + i * i;
      qq = p >> sh;
      return (qq > 65535) ? 16'hFFFF : qq[OUTN-1:0];
   endfunction

   always @(negedge clk) begin
      if (n_reset === 1'b1) begin
         if (v16 && out_ready) q16.push_back('{d16, i16, l16, cyc});
         if (v14 && out_ready) q14.push_back('{d14, i14, l14, cyc});
         if (o16) begin ov16_n++; ov16_cyc = cyc; end
         if (o14) ov14_n++;
         if (v16) vcnt++;
         if (hold_p) begin
            check("stall hold data", d16, hd);
            check("stall hold idx", i16, hi);
            check("stall hold last", l16, hl);
         end
         hold_p = v16 && !out_ready;
         hd = d16; hi = i16; hl = l16;
      end else begin
         hold_p = 1'b0;
      end
   end

   task automatic drive_frame(input int v);
      for (int k = 0; k < SIZE; k++)
         for (int j = 0; j < 2; j++) fft[k][j] = RN'($urandom);
      if (v >= 0) begin
         for (int k = 0; k < HALF; k++) begin
            fft[k][0] = tab[v].re[k];
            fft[k][1] = tab[v].im[k];
         end
      end
   endtask

   // Frame a starts at offset 0, optional frame b at offset gap.
   task automatic run_seq(input int a, input int b, input int gap, input bit stall, input bit exp_ov);
      int t0, n16, n14, ov0, ov14_0, nc, ne, fi, k, ec;
      word_t w;
      n16 = q16.size(); n14 = q14.size(); ov0 = ov16_n; ov14_0 = ov14_n;
      nc = gap + LAT + HALF + 12;
      @(posedge clk); #1;
      t0 = cyc;
      for (int c = 0; c < nc; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         start     = (c == 0) || (b >= 0 && c == gap);
         out_ready = !(stall && c >= LAT + 3 && c < LAT + 8);
         if (c == LAT) drive_frame(a);
         else if (b >= 0 && c == gap + LAT) drive_frame(b);
         else drive_frame(-1);
      end
      start = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      ne = (b >= 0 && !exp_ov) ? 2 * HALF : HALF;
      check($sformatf("seq v%0d word count", a), q16.size() - n16, ne);
      check($sformatf("seq v%0d word count s14", a), q14.size() - n14, ne);
      for (int i = 0; i < ne; i++) begin
         fi = (i < HALF) ? a : b;
         k  = i % HALF;
         ec = (i < HALF) ? t0 + LAT + 2 + k + ((stall && k >= 1) ? 5 : 0)
                         : t0 + gap + LAT + 2 + k;
         if (n16 + i < q16.size()) begin
            w = q16[n16 + i];
            check($sformatf("v%0d bin%0d data", fi, k), w.data, tab[fi].e16[k]);
            check($sformatf("v%0d bin%0d idx", fi, k), w.idx, k);
            check($sformatf("v%0d bin%0d last", fi, k), w.last, (k == HALF - 1));
            check($sformatf("v%0d bin%0d cycle", fi, k), w.cyc - t0, ec - t0);
         end
         if (n14 + i < q14.size()) begin
            w = q14[n14 + i];
            check($sformatf("v%0d bin%0d data s14", fi, k), w.data, tab[fi].e14[k]);
         end
      end
      check($sformatf("seq v%0d overrun count", a), ov16_n - ov0, exp_ov);
      check($sformatf("seq v%0d overrun count s14", a), ov14_n - ov14_0, exp_ov);
      if (exp_ov) check("overrun cycle", ov16_cyc - t0, gap + LAT + 1);
      check($sformatf("seq v%0d busy at end", a), b16, 0);
      check($sformatf("seq v%0d valid at end", a), v16, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      int t0, vc0;
      logic [11:0] s;

      // Directed: basic values and saturation corners.
      v.re = '0; v.im = '0;
      v.re[1] = 16'sd16384; v.im[2] = -16'sd16384;
      v.e16 = {16'd0, 16'd4096, 16'd4096, 16'd0};
      v.e14 = {16'd0, 16'd16384, 16'd16384, 16'd0};
      tab.push_back(v);
      v.re  = {16'd32767, 16'd128, 16'h8000, 16'h8000};
      v.im  = {16'd32767, 16'd0,   16'd0,    16'h8000};
      v.e16 = {16'd32766, 16'd0,   16'd16384, 16'd32768};
      v.e14 = {16'd65535, 16'd1,   16'd65535, 16'd65535};
      tab.push_back(v);
      // Random frames, alternating full-range and small magnitudes.
      for (int r = 0; r < 6; r++) begin
         for (int kk = 0; kk < HALF; kk++) begin
            if (r % 2 == 0) begin
               v.re[kk] = RN'($urandom);
               v.im[kk] = RN'($urandom);
            end else begin
               s = 12'($urandom); v.re[kk] = {{4{s[11]}}, s};
               s = 12'($urandom); v.im[kk] = {{4{s[11]}}, s};
            end
            v.e16[kk] = pw(v.re[kk], v.im[kk], 16);
            v.e14[kk] = pw(v.re[kk], v.im[kk], 14);
         end
         tab.push_back(v);
      end

      n_reset = 1'b1; start = 1'b0; out_ready = 1'b1;
      drive_frame(-1);
      #13 n_reset = 1'b0;
      #1;
      check("reset out_data", d16, 0);
      check("reset out_idx", i16, 0);
      check("reset out_valid", v16, 0);
      check("reset out_last", l16, 0);
      check("reset busy", b16, 0);
      check("reset overrun", o16, 0);
      check("reset out_valid s14", v14, 0);
      repeat (2) @(posedge clk);
      #1 n_reset = 1'b1;

      for (int i = 0; i < tab.size(); i++) run_seq(i, -1, 0, 1'b0, 1'b0);
      run_seq(2, -1, 0, 1'b1, 1'b0);             // backpressure at bin 1
      run_seq(3, 4, 2, 1'b0, 1'b1);              // dropped second frame
      run_seq(5, 6, HALF + 1, 1'b0, 1'b0);       // cap meets last handshake

      // Reset while bin 2 is presented, with a second start in flight.
      @(posedge clk); #1;
      t0 = cyc;
      for (int c = 0; c <= LAT + 4; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         start = (c == 0) || (c == LAT + 3);
         if (c == LAT) drive_frame(0); else drive_frame(-1);
      end
      #2;
      check("pre-reset valid", v16, 1);
      check("pre-reset idx", i16, 2);
      n_reset = 1'b0;
      #1;
      check("midrun reset valid", v16, 0);
      check("midrun reset busy", b16, 0);
      check("midrun reset data", d16, 0);
      check("midrun reset idx", i16, 0);
      check("midrun reset last", l16, 0);
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_reset = 1'b1;
      vc0 = vcnt;
      repeat (15) begin @(posedge clk); #1; drive_frame(-1); end
      @(negedge clk);
      check("post-reset valid cycles", vcnt - vc0, 0);
      check("post-reset busy", b16, 0);
      check("post-reset overrun count", o16, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
